// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the dmem slot arbiter.
// Optional feature macro: DMEM_ARB_WPROT_EN (game write protection below PROT_LIMIT).
package dmem_arb_pkg;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int SLOTS    = 4;
    localparam int CPU_SLOT = 0;

    // First address the game side may write when write protection is built in.
    localparam logic [ADDR_W-1:0] PROT_LIMIT = 12'h100;

    localparam int PHASE_W = $clog2(SLOTS);

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [PHASE_W-1:0] phase_t;

    // Who owns the memory slot that is about to start.
    typedef enum logic [1:0] {
        OWNER_CPU,
        OWNER_GAME,
        OWNER_IDLE
    } owner_e;

    localparam phase_t CPU_PHASE     = phase_t'(CPU_SLOT);
    // Slot during which the memory returns the processor's data.
    localparam phase_t CPU_RET_PHASE = phase_t'((CPU_SLOT + 1) % SLOTS);

    function automatic phase_t phase_inc(input phase_t p);
        return (int'(p) == SLOTS - 1) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_slot_arbiter_if.sv
// Bus bundle between the processor/game requesters, the arbiter and the dmem syncram.
// slave = arbiter view, master = environment view (requesters and memory).
interface dmem_slot_arbiter_if;
    import dmem_arb_pkg::*;

    // processor port
    addr_t  cpu_address;
    data_t  cpu_data;
    logic   cpu_wren;
    data_t  cpu_q;

    // game requester port
    logic   game_req;
    logic   game_wren;
    addr_t  game_address;
    data_t  game_data;
    logic   game_gnt;
    logic   game_valid;
    data_t  game_q;
    logic   game_wr_err;

    // syncram port
    addr_t  mem_address;
    data_t  mem_data;
    logic   mem_wren;
    data_t  mem_q;

    phase_t slot_phase;

    modport slave (
        input  cpu_address, cpu_data, cpu_wren,
        input  game_req, game_wren, game_address, game_data,
        input  mem_q,
        output cpu_q, game_gnt, game_valid, game_q, game_wr_err,
        output mem_address, mem_data, mem_wren, slot_phase
    );

    modport master (
        output cpu_address, cpu_data, cpu_wren,
        output game_req, game_wren, game_address, game_data,
        output mem_q,
        input  cpu_q, game_gnt, game_valid, game_q, game_wr_err,
        input  mem_address, mem_data, mem_wren, slot_phase
    );

endinterface

// File: rtl/dmem_slot_counter.sv
// Slot phase counter. Shares reset with the processor clock divider so that
// phase CPU_SLOT lines up with the processor edge.
module dmem_slot_counter
    import dmem_arb_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    output phase_t phase,
    output logic   cpu_next,   // slot starting at the next edge is the CPU slot
    output logic   cpu_ret     // current slot carries the CPU's returned data
);

    phase_t phase_d, phase_q;

    // Next phase: count 0..SLOTS-1 and wrap.
    always_comb phase_d = phase_inc(phase_q);

    // Phase register.
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) phase_q <= '0;
        else       phase_q <= phase_d;
    end

    assign phase    = phase_q;
    assign cpu_next = (phase_d == CPU_PHASE);
    assign cpu_ret  = (phase_q == CPU_RET_PHASE);

endmodule

// File: rtl/dmem_slot_arbiter.sv
// Time-division arbiter for the single-port dmem: one slot in SLOTS belongs to the
// processor, the others are granted to the game requester on demand.
// Optional feature macro: DMEM_ARB_WPROT_EN (block game writes below PROT_LIMIT).
module dmem_slot_arbiter
    import dmem_arb_pkg::*;
(
    input logic                clock,
    input logic                reset,
    dmem_slot_arbiter_if.slave bus
);

    phase_t phase;
    logic   cpu_next;
    logic   cpu_ret;

    dmem_slot_counter u_slot_counter (
        .clock    (clock),
        .reset    (reset),
        .phase    (phase),
        .cpu_next (cpu_next),
        .cpu_ret  (cpu_ret)
    );

    owner_e owner;

    addr_t mem_address_d, mem_address_q;
    data_t mem_data_d,    mem_data_q;
    logic  mem_wren_d,    mem_wren_q;
    logic  game_gnt_d,    game_gnt_q;
    logic  game_rd_d,     game_rd_q;     // granted access in this slot is a read
    logic  rd_pend_d,     rd_pend_q;     // game read data arrives from memory this slot
    logic  game_valid_d,  game_valid_q;
    data_t game_q_d,      game_q_q;
    data_t cpu_q_d,       cpu_q_q;
`ifdef DMEM_ARB_WPROT_EN
    logic  game_wr_err_d, game_wr_err_q;
`endif

    // Decide the owner of the upcoming slot and compute everything loaded at the edge.
    always_comb begin
        // NOTE: every _d gets a default first so no path through this block infers a latch.
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;
        game_gnt_d    = 1'b0;
        game_rd_d     = 1'b0;
        rd_pend_d     = game_rd_q;
        game_valid_d  = rd_pend_q;
        game_q_d      = rd_pend_q ? bus.mem_q : game_q_q;
        cpu_q_d       = cpu_ret   ? bus.mem_q : cpu_q_q;
`ifdef DMEM_ARB_WPROT_EN
        game_wr_err_d = 1'b0;
`endif

        // The CPU slot is never given away; a pending game request waits one more slot.
        if (cpu_next)          owner = OWNER_CPU;
        else if (bus.game_req) owner = OWNER_GAME;
        else                   owner = OWNER_IDLE;

        case (owner)
            OWNER_CPU: begin
                mem_address_d = bus.cpu_address;
                mem_data_d    = bus.cpu_data;
                mem_wren_d    = bus.cpu_wren;
            end
            OWNER_GAME: begin
                mem_address_d = bus.game_address;
                mem_data_d    = bus.game_data;
                game_gnt_d    = 1'b1;
                game_rd_d     = ~bus.game_wren;
`ifdef DMEM_ARB_WPROT_EN
                // Protected writes still consume their grant but never reach memory.
                if (bus.game_wren && (bus.game_address < PROT_LIMIT)) begin
                    mem_wren_d    = 1'b0;
                    game_wr_err_d = 1'b1;
                end else begin
                    mem_wren_d    = bus.game_wren;
                end
`else
                mem_wren_d    = bus.game_wren;
`endif
            end
            default: begin
            end
        endcase
    end

    // Registered memory drive, handshake pulses and read-data capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            game_gnt_q    <= 1'b0;
            game_rd_q     <= 1'b0;
            rd_pend_q     <= 1'b0;
            game_valid_q  <= 1'b0;
            game_q_q      <= '0;
            cpu_q_q       <= '0;
`ifdef DMEM_ARB_WPROT_EN
            game_wr_err_q <= 1'b0;
`endif
        end else begin
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            game_gnt_q    <= game_gnt_d;
            game_rd_q     <= game_rd_d;
            rd_pend_q     <= rd_pend_d;
            game_valid_q  <= game_valid_d;
            game_q_q      <= game_q_d;
            cpu_q_q       <= cpu_q_d;
`ifdef DMEM_ARB_WPROT_EN
            game_wr_err_q <= game_wr_err_d;
`endif
        end
    end

    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.mem_wren    = mem_wren_q;
    assign bus.game_gnt    = game_gnt_q;
    assign bus.game_valid  = game_valid_q;
    assign bus.game_q      = game_q_q;
    assign bus.cpu_q       = cpu_q_q;
    assign bus.slot_phase  = phase;
`ifdef DMEM_ARB_WPROT_EN
    assign bus.game_wr_err = game_wr_err_q;
`else
    assign bus.game_wr_err = 1'b0;
`endif

endmodule
